sandbox_kv_process: RTL and testbench

SANDBOX_KV_PROCESS -- requirements
Module: sandbox_kv_process

---
 rtl/sandbox_kv_process.sv | 207 ++++++++++++++++++++
 tb/tb_sandbox_kv_process.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sandbox_kv_process.sv
// rtl/sandbox_kv_process.sv - host-command key/value table with linear search and LED indicator
module sandbox_kv_process #(
    parameter int DATA_W = 32,
    parameter int KEY_W  = 8,
    parameter int VAL_W  = 8,
    parameter int DEPTH  = 16
) (
    input  logic              masterClock,
    input  logic              reset,
    input  logic              slowClock,
    input  logic              dataReceived,
    input  logic [7:0]        control,
    input  logic [DATA_W-1:0] inputData,
    output logic              clearDR,
    output logic              transmitData,
    output logic [7:0]        status,
    output logic [DATA_W-1:0] outputData,
    output logic              rxIndicator
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_DELETE = 2'd2;
    localparam logic [1:0] OP_CLEAR  = 2'd3;

    typedef enum logic [2:0] {IDLE, SEARCH, EXEC, RESP, HOLD, WAIT} state_t;
    typedef enum logic [2:0] {IND_IDLE, IND_HI1, IND_LO1, IND_HI2, IND_LO2} ind_t;

    state_t state;
    ind_t   ind_state;

    logic [DEPTH-1:0] ent_valid;
    logic [KEY_W-1:0] ent_key [DEPTH];
    logic [VAL_W-1:0] ent_val [DEPTH];

    logic [1:0]       op;
    logic [KEY_W-1:0] cmd_key;
    logic [VAL_W-1:0] cmd_val;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] hit_idx;
    logic [IDX_W-1:0] free_idx;
    logic             hit;
    logic             free_found;
    logic             exec_done;
    logic             success;
    logic             overflow;
    logic [CNT_W-1:0] count;
    logic [VAL_W-1:0] res_val;

    logic [DATA_W-1:0] resp_word;
    logic [7:0]        resp_status;
    logic              accept;
    logic              unused_bits;

    assign accept      = (state == IDLE) && dataReceived;
    assign unused_bits = ^{control[7:2], inputData[DATA_W-1:KEY_W+VAL_W]};

    always_comb begin
        resp_word          = '0;
        resp_word[VAL_W-1:0] = res_val;
        resp_word[23:16]   = 8'(count);
        resp_status        = {4'b0000, overflow, count == '0, count == CNT_W'(DEPTH), success};
    end

    // EXEC spends two cycles: the table update, then the response load from the updated count.
    always_ff @(posedge masterClock) begin
        if (reset) begin
            state        <= IDLE;
            ent_valid    <= '0;
            count        <= '0;
            clearDR      <= 1'b0;
            transmitData <= 1'b0;
            status       <= '0;
            outputData   <= '0;
            op           <= OP_READ;
            cmd_key      <= '0;
            cmd_val      <= '0;
            idx          <= '0;
            hit_idx      <= '0;
            free_idx     <= '0;
            hit          <= 1'b0;
            free_found   <= 1'b0;
            exec_done    <= 1'b0;
            success      <= 1'b0;
            overflow     <= 1'b0;
            res_val      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dataReceived) begin
                        op         <= control[1:0];
                        cmd_key    <= inputData[KEY_W-1:0];
                        cmd_val    <= inputData[KEY_W+VAL_W-1:KEY_W];
                        idx        <= '0;
                        hit        <= 1'b0;
                        free_found <= 1'b0;
                        exec_done  <= 1'b0;
                        state      <= (control[1:0] == OP_CLEAR) ? EXEC : SEARCH;
                    end
                end
                SEARCH: begin
                    if (ent_valid[idx] && ent_key[idx] == cmd_key) begin
                        hit     <= 1'b1;
                        hit_idx <= idx;
                        state   <= EXEC;
                    end else begin
                        if (!ent_valid[idx] && !free_found) begin
                            free_found <= 1'b1;
                            free_idx   <= idx;
                        end
                        if (idx == IDX_W'(DEPTH - 1)) state <= EXEC;
                        idx <= idx + IDX_W'(1);
                    end
                end
                EXEC: begin
                    if (!exec_done) begin
                        exec_done <= 1'b1;
                        success   <= 1'b0;
                        overflow  <= 1'b0;
                        res_val   <= '0;
                        case (op)
                            OP_READ: begin
                                success <= hit;
                                if (hit) res_val <= ent_val[hit_idx];
                            end
                            OP_WRITE: begin
                                if (hit) begin
                                    ent_val[hit_idx] <= cmd_val;
                                    success          <= 1'b1;
                                end else if (free_found) begin
                                    ent_valid[free_idx] <= 1'b1;
                                    ent_key[free_idx]   <= cmd_key;
                                    ent_val[free_idx]   <= cmd_val;
                                    count               <= count + CNT_W'(1);
                                    success             <= 1'b1;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end
                            OP_DELETE: begin
                                if (hit) begin
                                    ent_valid[hit_idx] <= 1'b0;
                                    count              <= count - CNT_W'(1);
                                    success            <= 1'b1;
                                end
                            end
                            default: begin
                                ent_valid <= '0;
                                count     <= '0;
                                success   <= 1'b1;
                            end
                        endcase
                    end else begin
                        status       <= resp_status;
                        outputData   <= resp_word;
                        transmitData <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: state <= HOLD;
                HOLD: begin
                    clearDR <= 1'b1;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (!dataReceived) begin
                        transmitData <= 1'b0;
                        clearDR      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Indicator: two full slowClock high/low periods, LED on during the second.
    always_ff @(posedge masterClock) begin
        if (reset) begin
            ind_state   <= IND_IDLE;
            rxIndicator <= 1'b0;
        end else begin
            case (ind_state)
                IND_IDLE: if (accept) ind_state <= IND_HI1;
                IND_HI1:  if (slowClock) ind_state <= IND_LO1;
                IND_LO1: begin
                    if (!slowClock) begin
                        rxIndicator <= 1'b1;
                        ind_state   <= IND_HI2;
                    end
                end
                IND_HI2:  if (slowClock) ind_state <= IND_LO2;
                IND_LO2: begin
                    if (!slowClock) begin
                        rxIndicator <= 1'b0;
                        ind_state   <= IND_IDLE;
                    end
                end
                default: ind_state <= IND_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sandbox_kv_process.sv
// tb/tb_sandbox_kv_process.sv - directed self-checking bench for sandbox_kv_process
module tb_sandbox_kv_process;

    localparam int DATA_W = 32;
    localparam int KEY_W  = 8;
    localparam int VAL_W  = 8;
    localparam int DEPTH  = 4;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        slow_clk = 1'b0;
    logic        data_rx  = 1'b0;
    logic [7:0]  control  = 8'h00;
    logic [31:0] in_data  = 32'h0;
    logic        clear_dr;
    logic        tx;
    logic        rx_ind;
    logic [7:0]  status;
    logic [31:0] out_data;

    int          total = 0;
    int          bad   = 0;
    logic        resp_phase = 1'b0;
    logic [7:0]  exp_st = 8'h00;
    logic [31:0] exp_od = 32'h0;

    logic        mv   [DEPTH];
    logic [7:0]  mk   [DEPTH];
    logic [7:0]  mval [DEPTH];

    sandbox_kv_process #(.DATA_W(DATA_W), .KEY_W(KEY_W), .VAL_W(VAL_W), .DEPTH(DEPTH)) dut (
        .masterClock (clk),
        .reset       (reset),
        .slowClock   (slow_clk),
        .dataReceived(data_rx),
        .control     (control),
        .inputData   (in_data),
        .clearDR     (clear_dr),
        .transmitData(tx),
        .status      (status),
        .outputData  (out_data),
        .rxIndicator (rx_ind)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Response words held while a response is outstanding.
    always @(negedge clk) begin
        if (resp_phase) begin
            check("resp_tx", tx, 1);
            check("resp_status", status, exp_st);
            check("resp_data", out_data, exp_od);
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
    endtask

    task automatic model_cmd(input logic [1:0] op, input logic [7:0] key, input logic [7:0] val,
                             output logic [7:0] st, output logic [31:0] od, output int lat);
        int   h;
        int   f;
        int   cnt;
        logic succ;
        logic ovf;
        logic [7:0] rv;
        h = -1; f = -1; cnt = 0; succ = 1'b0; ovf = 1'b0; rv = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (h < 0 && mv[i] && mk[i] == key) h = i;
            if (f < 0 && !mv[i]) f = i;
        end
        lat = (op == 2'd3) ? 2 : ((h >= 0) ? h + 3 : DEPTH + 2);
        case (op)
            2'd0: if (h >= 0) begin succ = 1'b1; rv = mval[h]; end
            2'd1: begin
                if (h >= 0) begin
                    succ = 1'b1; mval[h] = val;
                end else if (f >= 0) begin
                    succ = 1'b1; mv[f] = 1'b1; mk[f] = key; mval[f] = val;
                end else begin
                    ovf = 1'b1;
                end
            end
            2'd2: if (h >= 0) begin succ = 1'b1; mv[h] = 1'b0; end
            default: begin succ = 1'b1; model_clear(); end
        endcase
        for (int i = 0; i < DEPTH; i++) if (mv[i]) cnt++;
        st = {4'b0000, ovf, cnt == 0, cnt == DEPTH, succ};
        od = (32'(cnt) << 16) | {24'h0, rv};
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] key, input logic [7:0] val,
                          input int hold, input bit pin, input logic [7:0] pin_st,
                          input logic [31:0] pin_od, input int pin_lat, input bit rel_reset);
        logic [7:0]  st;
        logic [31:0] od;
        int          lat;
        int          n;
        model_cmd(op, key, val, st, od, lat);
        if (pin) begin
            check("pin_status", st, pin_st);
            check("pin_data", od, pin_od);
            check("pin_latency", lat, pin_lat);
        end
        exp_st = st;
        exp_od = od;
        @(negedge clk);
        if (rel_reset) reset = 1'b0;
        control = {6'b101101, op};
        in_data = {16'hBEEF, val, key};
        data_rx = 1'b1;
        @(posedge clk); #1;
        control = ~control;
        in_data = ~in_data;
        n = 0;
        while (n < 40 && !tx) begin @(posedge clk); #1; n++; end
        check("tx_latency", n, lat);
        resp_phase = 1'b1;
        n = 0;
        while (n < 10 && !clear_dr) begin @(posedge clk); #1; n++; end
        check("cleardr_delay", n, 2);
        repeat (hold) @(negedge clk);
        @(negedge clk);
        resp_phase = 1'b0;
        data_rx    = 1'b0;
        @(posedge clk); #1;
        check("tx_release", tx, 0);
        check("cleardr_release", clear_dr, 0);
    endtask

    task automatic slow_pulse();
        @(negedge clk) slow_clk = 1'b1;
        @(negedge clk) slow_clk = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", tx, 0);
        check("rst_cleardr", clear_dr, 0);
        check("rst_status", status, 0);
        check("rst_data", out_data, 0);
        check("rst_ind", rx_ind, 0);

        do_cmd(2'd1, 8'h11, 8'hA5, 1, 1, 8'h01, 32'h0001_0000, 6, 1);
        check("ind_waiting", rx_ind, 0);
        slow_pulse();
        check("ind_set", rx_ind, 1);

        do_cmd(2'd0, 8'h11, 8'h00, 1, 1, 8'h01, 32'h0001_00A5, 3, 0);
        do_cmd(2'd0, 8'h22, 8'h00, 1, 1, 8'h00, 32'h0001_0000, 6, 0);
        check("ind_hold", rx_ind, 1);
        slow_pulse();
        check("ind_clear", rx_ind, 0);

        do_cmd(2'd3, 8'h00, 8'h00, 10, 1, 8'h05, 32'h0000_0000, 2, 0);

        do_cmd(2'd1, 8'h01, 8'h10, 1, 0, 8'h00, 32'h0, 0, 0);
        do_cmd(2'd1, 8'h02, 8'h20, 1, 0, 8'h00, 32'h0, 0, 0);
        do_cmd(2'd1, 8'h03, 8'h30, 1, 0, 8'h00, 32'h0, 0, 0);
        do_cmd(2'd1, 8'h04, 8'h40, 1, 1, 8'h03, 32'h0004_0000, 6, 0);
        do_cmd(2'd1, 8'h05, 8'h50, 1, 1, 8'h0A, 32'h0004_0000, 6, 0);
        do_cmd(2'd0, 8'h03, 8'h00, 1, 1, 8'h03, 32'h0004_0030, 5, 0);
        do_cmd(2'd0, 8'h05, 8'h00, 1, 1, 8'h02, 32'h0004_0000, 6, 0);

        do_cmd(2'd2, 8'h02, 8'h00, 1, 1, 8'h01, 32'h0003_0000, 4, 0);
        do_cmd(2'd1, 8'h09, 8'h99, 1, 1, 8'h03, 32'h0004_0000, 6, 0);
        do_cmd(2'd0, 8'h09, 8'h00, 1, 1, 8'h03, 32'h0004_0099, 4, 0);
        do_cmd(2'd1, 8'h03, 8'h77, 2, 1, 8'h03, 32'h0004_0000, 5, 0);

        slow_pulse();
        check("ind_set2", rx_ind, 1);

        @(negedge clk);
        control = 8'h00;
        in_data = {16'h0, 8'h00, 8'h04};
        data_rx = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        reset   = 1'b1;
        data_rx = 1'b0;
        @(posedge clk); #1;
        check("midrst_tx", tx, 0);
        check("midrst_cleardr", clear_dr, 0);
        check("midrst_status", status, 0);
        check("midrst_data", out_data, 0);
        check("midrst_ind", rx_ind, 0);
        model_clear();

        do_cmd(2'd0, 8'h04, 8'h00, 1, 1, 8'h04, 32'h0000_0000, 6, 1);
        do_cmd(2'd2, 8'h55, 8'h00, 1, 1, 8'h04, 32'h0000_0000, 6, 0);
        do_cmd(2'd1, 8'h33, 8'h44, 1, 0, 8'h00, 32'h0, 0, 0);
        do_cmd(2'd0, 8'h33, 8'h00, 1, 1, 8'h01, 32'h0001_0044, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
